// File: rtl/alu_regfile_datapath_pkg.sv
// Shared widths and opcode encodings for the
// execution datapath.
package dp_pkg;

  localparam int DP_DATA_W = 16;
  localparam int DP_ADDR_W = 3;

  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_OUT  = 4'b1111;

endpackage

// File: rtl/alu_regfile_datapath_if.sv
// Decoder <-> datapath bus: register addresses,
// write port, opcode and ALU results.
interface alu_regfile_datapath_if
  import dp_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W
);

  logic [ADDR_W-1:0] address_a;
  logic [ADDR_W-1:0] address_b;
  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] alu_result;
  logic              zero;

  modport master (
    output address_a, address_b,
    output write_enable, write_data,
    output opcode,
    input  data_a, data_b,
    input  alu_result, zero
  );

  modport slave (
    input  address_a, address_b,
    input  write_enable, write_data,
    input  opcode,
    output data_a, data_b,
    output alu_result, zero
  );

endinterface

// File: rtl/alu_regfile_datapath_regbank.sv
// Register storage: sync reset, one sync write
// port, two async read ports, no bypass.
module dp_regbank
  import dp_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (write_enable) begin
      regs[address_a] <= write_data;
    end
  end

  assign data_a = regs[address_a];
  assign data_b = regs[address_b];

endmodule

// File: rtl/alu_regfile_datapath.sv
// Execution datapath: register bank plus a
// combinational ALU over its two read values.
module alu_regfile_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_regfile_datapath_if.slave bus
);

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] res;

  dp_regbank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regbank (
    .clk          (clk),
    .rst_n        (rst_n),
    .address_a    (bus.address_a),
    .address_b    (bus.address_b),
    .write_enable (bus.write_enable),
    .write_data   (bus.write_data),
    .data_a       (a),
    .data_b       (b)
  );

  // Unlisted opcodes pass a through so loads
  // and branches can reuse the result path.
  always_comb begin
    res = a;
    case (bus.opcode)
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: res = a << b[3:0];
      OP_SHR: res = a >> b[3:0];
      default: res = a;
    endcase
  end

  assign bus.data_a     = a;
  assign bus.data_b     = b;
  assign bus.alu_result = res;
  assign bus.zero       = (res == '0);

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench: ALU vector table plus hand
// sequences for reset, latency and write gating.
module tb_alu_regfile_datapath;
  import dp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  alu_regfile_datapath_if bus ();

  alu_regfile_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        z;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] addr,
                    input logic [15:0] data);
    @(negedge clk);
    bus.address_a    = addr;
    bus.write_data   = data;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h0005, 16'h0003, OP_ADD, 16'h0008, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0003, OP_SUB, 16'h0002, 1'b0};
    vecs[2]  = '{16'h0003, 16'h0003, OP_SUB, 16'h0000, 1'b1};
    vecs[3]  = '{16'h0000, 16'h0001, OP_SUB, 16'hFFFF, 1'b0};
    vecs[4]  = '{16'h00F0, 16'h0F0F, OP_AND, 16'h0000, 1'b1};
    vecs[5]  = '{16'h00F0, 16'h0F0F, OP_OR,  16'h0FFF, 1'b0};
    vecs[6]  = '{16'h00F0, 16'h0F0F, OP_XOR, 16'h0FFF, 1'b0};
    vecs[7]  = '{16'h00F0, 16'h0F0F, OP_NOT, 16'hFF0F, 1'b0};
    vecs[8]  = '{16'h8001, 16'h0001, OP_SHL, 16'h0002, 1'b0};
    vecs[9]  = '{16'h8001, 16'h0001, OP_SHR, 16'h4000, 1'b0};
    vecs[10] = '{16'h0001, 16'h0013, OP_SHL, 16'h0008, 1'b0};
    vecs[11] = '{16'h1234, 16'h0F0F, OP_ADDI, 16'h1234, 1'b0};
    vecs[12] = '{16'h0000, 16'h5555, OP_JMP, 16'h0000, 1'b1};
    vecs[13] = '{16'hFFFF, 16'h0000, OP_NOT, 16'h0000, 1'b1};
    vecs[14] = '{16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1};

    bus.address_a    = '0;
    bus.address_b    = '0;
    bus.write_enable = 1'b0;
    bus.write_data   = '0;
    bus.opcode       = OP_ADD;

    // reset, then every address reads zero
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.address_a = 3'(i);
      bus.address_b = 3'(7 - i);
      #1;
      chk($sformatf("rst_a%0d", i), bus.data_a, 16'h0);
      chk($sformatf("rst_b%0d", i), bus.data_b, 16'h0);
    end
    chk("rst_zero", {15'h0, bus.zero}, 16'h1);

    // write latency: old value until the edge
    @(negedge clk);
    bus.address_a    = 3'd1;
    bus.write_data   = 16'h0005;
    bus.write_enable = 1'b1;
    #1;
    chk("lat_pre_r1", bus.data_a, 16'h0000);
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    chk("lat_post_r1", bus.data_a, 16'h0005);
    @(negedge clk);
    bus.address_a    = 3'd2;
    bus.address_b    = 3'd2;
    bus.write_data   = 16'h0003;
    bus.write_enable = 1'b1;
    #1;
    chk("lat_pre_r2", bus.data_b, 16'h0000);
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    chk("lat_post_r2", bus.data_b, 16'h0003);

    // ALU table, operands loaded into r1/r2
    for (int i = 0; i < 15; i++) begin
      wr(3'd1, vecs[i].a);
      wr(3'd2, vecs[i].b);
      bus.address_a = 3'd1;
      bus.address_b = 3'd2;
      bus.opcode    = vecs[i].op;
      #1;
      chk($sformatf("alu%0d_res", i),
          bus.alu_result, vecs[i].res);
      chk($sformatf("alu%0d_zero", i),
          {15'h0, bus.zero}, {15'h0, vecs[i].z});
    end

    // r0 is ordinary storage
    wr(3'd0, 16'h7777);
    bus.address_b = 3'd0;
    #1;
    chk("r0_store", bus.data_b, 16'h7777);

    // write_enable low blocks the write
    wr(3'd3, 16'h1111);
    @(negedge clk);
    bus.address_a    = 3'd3;
    bus.write_data   = 16'hBEEF;
    bus.write_enable = 1'b0;
    @(posedge clk);
    #1;
    chk("we_gate", bus.data_a, 16'h1111);

    // reset wins over a simultaneous write
    @(negedge clk);
    rst_n            = 1'b0;
    bus.address_a    = 3'd3;
    bus.write_data   = 16'hAAAA;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    rst_n            = 1'b0;
    bus.write_enable = 1'b0;
    rst_n            = 1'b1;
    chk("rst_prio_r3", bus.data_a, 16'h0000);
    bus.address_b = 3'd0;
    #1;
    chk("rst_clr_r0", bus.data_b, 16'h0000);

    // same address on both ports, pass-through
    wr(3'd4, 16'h1234);
    bus.address_a = 3'd4;
    bus.address_b = 3'd4;
    bus.opcode    = OP_OUT;
    #1;
    chk("same_a", bus.data_a, 16'h1234);
    chk("same_b", bus.data_b, 16'h1234);
    chk("out_res", bus.alu_result, 16'h1234);
    chk("out_zero", {15'h0, bus.zero}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_regfile_datapath.md
Name: alu_regfile_datapath

Overview:
Execution datapath for the 16-bit accumulator-style processor. It contains an 8-entry x 16-bit register file with two combinational read ports and one synchronous write port, plus a combinational ALU that operates on the two read values. The top-level decoder drives register addresses, opcode, write enable and write data, and consumes the ALU result and zero flag.

Parameters:
DATA_W, 16, register and ALU data width.
ADDR_W, 3, register address width; the file holds 2**ADDR_W entries.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous reset, active-low.
address_a  in  ADDR_W  read port A address; also the write address.
address_b  in  ADDR_W  read port B address.
write_enable  in  1  when 1, write write_data to register[address_a] at the rising edge.
write_data  in  DATA_W  data to write; the decoder muxes the ALU result or the immediate onto it.
opcode  in  4  ALU operation select.
data_a  out  DATA_W  register[address_a], combinational.
data_b  out  DATA_W  register[address_b], combinational.
alu_result  out  DATA_W  ALU output, combinational.
zero  out  1  1 when alu_result == 0, combinational.

Behaviour:
- Reset: on a rising edge with rst_n=0, all 8 registers clear to 0. data_a, data_b and alu_result therefore read 0, and zero reads 1 for any opcode except 0111 (NOT). Reset has priority over write_enable.
- Write: on a rising edge with rst_n=1 and write_enable=1, register[address_a] <= write_data. Latency is 1 cycle.
- Read: asynchronous. Register 0 is ordinary storage and is not hardwired to zero.
- Read-during-write: before the edge, data_a and data_b show the old value. From the edge onward they show the new value. There is no bypass path.
- Same address on both ports: data_a == data_b.
- ALU opcodes (a = data_a, b = data_b). All arithmetic is modulo 2**16, unsigned, with no carry or overflow output.
  - 0010 ADD: a + b.
  - 0011 SUB: a - b, wrapping (0 - 1 = 0xFFFF).
  - 0100 AND: a & b.
  - 0101 OR: a | b.
  - 0110 XOR: a ^ b.
  - 0111 NOT: ~a.
  - 1001 SHL: a << b[3:0].
  - 1010 SHR: a >> b[3:0], logical shift.
  - Any other opcode (including 0001 ADDI/load, 1000 JMP, 1100 BR, 1111 OUT): a, pass-through.
- zero is asserted for every opcode whenever alu_result == 0. The decoder decides when to latch it; this block holds no flag register.
- X-free: every output is defined for all input combinations after the first reset.

Decomposition:
- Shared package dp_pkg holds:
  - the DATA_W and ADDR_W defaults;
  - the opcode localparams OP_ADDI=4'b0001, OP_ADD=4'b0010, OP_SUB=4'b0011, OP_AND=4'b0100, OP_OR=4'b0101, OP_XOR=4'b0110, OP_NOT=4'b0111, OP_JMP=4'b1000, OP_SHL=4'b1001, OP_SHR=4'b1010, OP_BR=4'b1100, OP_OUT=4'b1111.
- One natural sub-module, dp_regbank: the 8x16 storage with reset, write and two read ports. The ALU stays inline as a combinational case statement in the top.

Test Plan:
- Reset then read: rst_n=0 for 1 cycle, then read all 8 addresses -> data_a = data_b = 0x0000; opcode=0010 gives zero=1.
- Write/read and latency: write 0x0005 to r1 and 0x0003 to r2 -> each value visible on data_a/data_b only after its write edge. Before that edge the old value (0) is visible.
- ADD/SUB/zero: r1=5, r2=3, opcode 0010 -> 0x0008, zero=0. Opcode 0011 -> 0x0002. With r1=r2=3, SUB -> 0x0000, zero=1. With a=0, b=1, SUB -> 0xFFFF.
- Logic and shifts: a=0x00F0, b=0x0F0F -> AND 0x0000 (zero=1), OR 0x0FFF, XOR 0x0FFF, NOT 0xFF0F. a=0x8001, b=0x0001 -> SHL 0x0002, SHR 0x4000.
- Write-enable gating and reset priority: write_enable=0 with write_data=0xBEEF -> no register changes. Reset asserted together with write_enable=1 -> the target register reads 0.
- Same-address and pass-through: address_a = address_b = r4 holding 0x1234 -> data_a = data_b = 0x1234. Opcode 1111 -> alu_result = 0x1234, zero=0.
